riscv_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core. It generates the stall, flush and freeze enables consumed by the F/D/E/M/W pipeline registers, and the E-stage forwarding selects. It sequences multi-cycle load-use bubbles, branch/jump redirects, and instruction/data memory wait states. It also keeps saturating stall/flush event counters for performance bring-up.

---
 rtl/riscv_hazard_ctrl_pkg.sv | 18 +
 rtl/riscv_fwd_sel.sv | 28 ++
 rtl/riscv_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_riscv_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_hazard_ctrl_pkg.sv
// rtl/riscv_hazard_ctrl_pkg.sv - shared core configs: XLEN, forwarding and hazard FSM encodings
// Purpose: constants shared by the hazard controller and its forwarding selector.
// Ports:   none (package).
package riscv_hazard_ctrl_pkg;

    localparam int XLEN = 32;

    // E-stage operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // Hazard FSM states
    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_LU    = 2'b01;
    localparam logic [1:0] ST_DWAIT = 2'b10;

endpackage

// File: rtl/riscv_fwd_sel.sv
// rtl/riscv_fwd_sel.sv - combinational forwarding select for one E-stage operand
// Purpose: pick the newest in-flight producer of an E-stage source register.
// Ports:   i_rs_addrE  source register in E
//          i_rd_addrM / i_reg_wr_enM  M-stage producer
//          i_rd_addrW / i_reg_wr_enW  W-stage producer
//          o_fwd  operand select (FWD_REG / FWD_M / FWD_W)
module riscv_fwd_sel
    import riscv_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs_addrE,
    input  logic [4:0] i_rd_addrM,
    input  logic       i_reg_wr_enM,
    input  logic [4:0] i_rd_addrW,
    input  logic       i_reg_wr_enW,
    output logic [1:0] o_fwd
);

    always_comb begin
        o_fwd = FWD_REG;
        // M holds the younger result, so it takes precedence over W; x0 is never forwarded
        if (i_reg_wr_enM && (i_rd_addrM != 5'd0) && (i_rd_addrM == i_rs_addrE)) begin
            o_fwd = FWD_M;
        end else if (i_reg_wr_enW && (i_rd_addrW != 5'd0) && (i_rd_addrW == i_rs_addrE)) begin
            o_fwd = FWD_W;
        end
    end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// rtl/riscv_hazard_ctrl.sv - 5-stage pipeline hazard controller with event counters
// Purpose: stall/flush/freeze enables, E-stage forwarding selects, stall/flush counters.
// Ports:   i_clk, i_rst (async, active-high)
//          D/E/M/W register addresses and write enables, i_result_srcE (E is a load),
//          i_pc_srcE (redirect), i_dmem_reqM/i_dmem_ready, i_imem_ready
//          o_hazard_stallF/stallD/flushD/flushE/freeze, o_fwd_aE/o_fwd_bE,
//          o_cnt_stall (stall/freeze cycles), o_cnt_flush (redirects)
module riscv_hazard_ctrl
    import riscv_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_rs1_addrD,
    input  logic [4:0]       i_rs2_addrD,
    input  logic [4:0]       i_rs1_addrE,
    input  logic [4:0]       i_rs2_addrE,
    input  logic [4:0]       i_rd_addrE,
    input  logic             i_result_srcE,
    input  logic             i_reg_wr_enE,
    input  logic             i_pc_srcE,
    input  logic [4:0]       i_rd_addrM,
    input  logic             i_reg_wr_enM,
    input  logic [4:0]       i_rd_addrW,
    input  logic             i_reg_wr_enW,
    input  logic             i_dmem_reqM,
    input  logic             i_dmem_ready,
    input  logic             i_imem_ready,
    output logic             o_hazard_stallF,
    output logic             o_hazard_stallD,
    output logic             o_hazard_flushD,
    output logic             o_hazard_flushE,
    output logic             o_hazard_freeze,
    output logic [1:0]       o_fwd_aE,
    output logic [1:0]       o_fwd_bE,
    output logic [CNT_W-1:0] o_cnt_stall,
    output logic [CNT_W-1:0] o_cnt_flush
);

    localparam logic [2:0]       BUBBLES_M1 = 3'(LOAD_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q;

    logic stallF, stallD, flushD, flushE, freeze;
    logic dmem_wait, load_use, in_lu;
    logic [1:0] fwd_a, fwd_b;

    assign dmem_wait = i_dmem_reqM && !i_dmem_ready;
    assign load_use  = i_result_srcE && i_reg_wr_enE && (i_rd_addrE != 5'd0) &&
                       ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));
    // DWAIT keeps the LU context in the bubble counter, so the saved state is
    // recovered from it in the very cycle the wait ends
    assign in_lu     = (state_q == ST_LU) || ((state_q == ST_DWAIT) && (bcnt_q != 3'd0));

    always_comb begin
        stallF  = 1'b0;
        stallD  = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        freeze  = 1'b0;
        bcnt_d  = bcnt_q;
        state_d = in_lu ? ST_LU : ST_RUN;
        if (dmem_wait) begin
            stallF  = 1'b1;
            stallD  = 1'b1;
            freeze  = 1'b1;
            state_d = ST_DWAIT;
        end else if (i_pc_srcE) begin
            // D holds a wrong-path instruction, so any pending bubbles are moot
            flushD  = 1'b1;
            flushE  = 1'b1;
            bcnt_d  = 3'd0;
            state_d = ST_RUN;
        end else if (in_lu) begin
            stallF  = 1'b1;
            stallD  = 1'b1;
            flushE  = 1'b1;
            bcnt_d  = bcnt_q - 3'd1;
            state_d = (bcnt_q == 3'd1) ? ST_RUN : ST_LU;
        end else if (load_use) begin
            stallF  = 1'b1;
            stallD  = 1'b1;
            flushE  = 1'b1;
            bcnt_d  = BUBBLES_M1;
            state_d = (BUBBLES_M1 != 3'd0) ? ST_LU : ST_RUN;
        end else if (!i_imem_ready) begin
            stallF  = 1'b1;
            flushD  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            bcnt_q      <= 3'd0;
            cnt_stall_q <= '0;
            cnt_flush_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            if ((stallF || stallD || freeze) && (cnt_stall_q != CNT_MAX)) begin
                cnt_stall_q <= cnt_stall_q + CNT_ONE;
            end
            if (flushE && !stallD && (cnt_flush_q != CNT_MAX)) begin
                // flushE without a stall only occurs on a redirect
                cnt_flush_q <= cnt_flush_q + CNT_ONE;
            end
        end
    end

    riscv_fwd_sel u_fwd_a (
        .i_rs_addrE   (i_rs1_addrE),
        .i_rd_addrM   (i_rd_addrM),
        .i_reg_wr_enM (i_reg_wr_enM),
        .i_rd_addrW   (i_rd_addrW),
        .i_reg_wr_enW (i_reg_wr_enW),
        .o_fwd        (fwd_a)
    );

    riscv_fwd_sel u_fwd_b (
        .i_rs_addrE   (i_rs2_addrE),
        .i_rd_addrM   (i_rd_addrM),
        .i_reg_wr_enM (i_reg_wr_enM),
        .i_rd_addrW   (i_rd_addrW),
        .i_reg_wr_enW (i_reg_wr_enW),
        .o_fwd        (fwd_b)
    );

    // All enables and selects are forced quiet while reset is held
    assign o_hazard_stallF = stallF && !i_rst;
    assign o_hazard_stallD = stallD && !i_rst;
    assign o_hazard_flushD = flushD && !i_rst;
    assign o_hazard_flushE = flushE && !i_rst;
    assign o_hazard_freeze = freeze && !i_rst;
    assign o_fwd_aE        = i_rst ? FWD_REG : fwd_a;
    assign o_fwd_bE        = i_rst ? FWD_REG : fwd_b;
    assign o_cnt_stall     = cnt_stall_q;
    assign o_cnt_flush     = cnt_flush_q;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// tb/tb_riscv_hazard_ctrl.sv - directed self-checking bench for riscv_hazard_ctrl
module tb_riscv_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       res_srcE, wrE, pc_srcE, wrM, wrW, dreq, drdy, irdy;

    logic       s1F, s1D, f1D, f1E, z1;
    logic [1:0] a1, b1;
    logic [31:0] cs1, cf1;
    logic       s3F, s3D, f3D, f3E, z3;
    logic [1:0] a3, b3;
    logic [31:0] cs3, cf3;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    riscv_hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(32)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_addrD(rs1D), .i_rs2_addrD(rs2D),
        .i_rs1_addrE(rs1E), .i_rs2_addrE(rs2E), .i_rd_addrE(rdE),
        .i_result_srcE(res_srcE), .i_reg_wr_enE(wrE), .i_pc_srcE(pc_srcE),
        .i_rd_addrM(rdM), .i_reg_wr_enM(wrM), .i_rd_addrW(rdW), .i_reg_wr_enW(wrW),
        .i_dmem_reqM(dreq), .i_dmem_ready(drdy), .i_imem_ready(irdy),
        .o_hazard_stallF(s1F), .o_hazard_stallD(s1D), .o_hazard_flushD(f1D),
        .o_hazard_flushE(f1E), .o_hazard_freeze(z1),
        .o_fwd_aE(a1), .o_fwd_bE(b1), .o_cnt_stall(cs1), .o_cnt_flush(cf1)
    );

    riscv_hazard_ctrl #(.LOAD_BUBBLES(3), .CNT_W(32)) dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_addrD(rs1D), .i_rs2_addrD(rs2D),
        .i_rs1_addrE(rs1E), .i_rs2_addrE(rs2E), .i_rd_addrE(rdE),
        .i_result_srcE(res_srcE), .i_reg_wr_enE(wrE), .i_pc_srcE(pc_srcE),
        .i_rd_addrM(rdM), .i_reg_wr_enM(wrM), .i_rd_addrW(rdW), .i_reg_wr_enW(wrW),
        .i_dmem_reqM(dreq), .i_dmem_ready(drdy), .i_imem_ready(irdy),
        .o_hazard_stallF(s3F), .o_hazard_stallD(s3D), .o_hazard_flushD(f3D),
        .o_hazard_flushE(f3E), .o_hazard_freeze(z3),
        .o_fwd_aE(a3), .o_fwd_bE(b3), .o_cnt_stall(cs3), .o_cnt_flush(cf3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pack the five enables as {stallF, stallD, flushD, flushE, freeze}
    function automatic logic [31:0] en1();
        return {27'd0, s1F, s1D, f1D, f1E, z1};
    endfunction
    function automatic logic [31:0] en3();
        return {27'd0, s3F, s3D, f3D, f3E, z3};
    endfunction

    task automatic idle();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        res_srcE = 0; wrE = 0; pc_srcE = 0; wrM = 0; wrW = 0;
        dreq = 0; drdy = 1; irdy = 1;
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic lw_x5_hazard();
        res_srcE = 1; wrE = 1; rdE = 5; rs1D = 5; rs2D = 1;
    endtask

    task automatic e_bubble_lw_in_m();
        res_srcE = 0; wrE = 0; rdE = 0; rdM = 5; wrM = 1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // Reset: outputs quiet even with every trigger active
        pc_srcE = 1; irdy = 0; dreq = 1; drdy = 0; wrM = 1; rdM = 3; rs1E = 3; rs2E = 3;
        #2;
        chk("rst_enables", en1(), 32'h00);
        chk("rst_fwd_a", {30'd0, a1}, 32'h0);
        chk("rst_cnt_stall", cs1, 32'd0);
        do_reset();

        // Load-use, LOAD_BUBBLES=1
        lw_x5_hazard();
        #1;
        chk("lu1_enables", en1(), 32'b11010);
        step();
        idle(); e_bubble_lw_in_m(); rs1D = 5; rs2D = 1;
        #1;
        chk("lu1_released", en1(), 32'b00000);
        step();
        idle(); rdW = 5; wrW = 1; rs1E = 5; rs2E = 1; rdE = 6; wrE = 1;
        #1;
        chk("lu1_fwd_a_w", {30'd0, a1}, 32'b01);
        chk("lu1_fwd_b_reg", {30'd0, b1}, 32'b00);
        chk("lu1_cnt_stall", cs1, 32'd1);

        // Load-use, LOAD_BUBBLES=3
        do_reset();
        lw_x5_hazard();
        #1;
        chk("lu3_c0", en3(), 32'b11010);
        step();
        idle(); e_bubble_lw_in_m();
        #1;
        chk("lu3_c1", en3(), 32'b11010);
        step();
        chk("lu3_c2", en3(), 32'b11010);
        step();
        chk("lu3_c3_run", en3(), 32'b00000);
        chk("lu3_cnt_stall", cs3, 32'd3);

        // Redirect together with load-use
        do_reset();
        lw_x5_hazard(); pc_srcE = 1;
        #1;
        chk("redir_lu_enables", en1(), 32'b00110);
        step();
        idle();
        #1;
        chk("redir_cnt_flush", cf1, 32'd1);
        chk("redir_cnt_stall", cs1, 32'd0);
        chk("redir_after_run", en1(), 32'b00000);

        // Data memory wait inside LU with two bubbles pending
        do_reset();
        lw_x5_hazard();
        step();
        idle(); e_bubble_lw_in_m(); dreq = 1; drdy = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("dwait_freeze_%0d", i), en3(), 32'b11001);
            step();
        end
        dreq = 0; drdy = 1;
        #1;
        chk("dwait_lu_a", en3(), 32'b11010);
        step();
        chk("dwait_lu_b", en3(), 32'b11010);
        step();
        chk("dwait_run", en3(), 32'b00000);
        chk("dwait_cnt_stall", cs3, 32'd7);

        // Redirect deferred behind a data memory wait
        do_reset();
        pc_srcE = 1; dreq = 1; drdy = 0;
        #1;
        chk("defer_frozen", en1(), 32'b11001);
        step();
        drdy = 1;
        #1;
        chk("defer_redirect", en1(), 32'b00110);
        step();
        idle();
        #1;
        chk("defer_cnt_flush", cf1, 32'd1);

        // Instruction memory wait
        irdy = 0;
        #1;
        chk("imem_wait", en1(), 32'b10100);
        irdy = 1;

        // Forwarding
        wrM = 1; rdM = 0; wrW = 1; rdW = 0; rs1E = 0; rs2E = 0;
        #1;
        chk("fwd_x0_a", {30'd0, a1}, 32'b00);
        rdM = 7; rdW = 7; rs1E = 7; rs2E = 7;
        #1;
        chk("fwd_m_over_w_a", {30'd0, a1}, 32'b10);
        chk("fwd_m_over_w_b", {30'd0, b1}, 32'b10);
        rdM = 9; rs2E = 9; rs1E = 7;
        #1;
        chk("fwd_w_only_a", {30'd0, a1}, 32'b01);
        chk("fwd_m_b", {30'd0, b1}, 32'b10);
        wrM = 0;
        #1;
        chk("fwd_m_disabled_b", {30'd0, b1}, 32'b00);
        // Load-use from x0 never stalls
        idle(); res_srcE = 1; wrE = 1; rdE = 0; rs1D = 0;
        #1;
        chk("lu_x0_none", en1(), 32'b00000);

        // Asynchronous reset in the middle of a data memory wait
        do_reset();
        dreq = 1; drdy = 0; wrM = 1; rdM = 4; rs1E = 4;
        for (int i = 0; i < 9; i++) step();
        chk("pre_rst_cnt_stall", cs1, 32'd9);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_enables", en1(), 32'h00);
        chk("async_rst_fwd_a", {30'd0, a1}, 32'b00);
        chk("async_rst_cnt_stall", cs1, 32'd0);
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("post_rst_run", en1(), 32'b00000);
        step();
        chk("post_rst_cnt_stall", cs1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
